// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes,
// FSM state encoding and byte-enable patterns.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, access legality and load extension for the LSU.
// Purely combinational; no state, no flow control.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_st,
    output logic        bad,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata_word,
    output logic [31:0] rdata_ext
);

    logic       ld_ok;
    logic       st_ok;
    logic       mis;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be       = BE_NONE;
        wdata_st = wdata;
        case (funct3[1:0])
            2'b00: begin
                be       = BE_B0 << addr_lo;
                wdata_st = {4{wdata[7:0]}};
            end
            2'b01: begin
                be       = addr_lo[1] ? BE_HI : BE_LO;
                wdata_st = {2{wdata[15:0]}};
            end
            2'b10:   be = BE_W;
            default: be = BE_NONE;
        endcase
    end

    always_comb begin
        ld_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (funct3 == F3_BU) || (funct3 == F3_HU);
        st_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        mis   = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        bad   = (mem_read && mem_write) || (mem_read && !ld_ok) ||
                (mem_write && !st_ok) || mis;
    end

    always_comb begin
        byte_sel  = rdata_word[{ld_addr_lo, 3'b000} +: 8];
        half_sel  = ld_addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
        rdata_ext = '0;
        case (ld_funct3)
            F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_ext = {24'b0, byte_sel};
            F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_ext = {16'b0, half_sel};
            F3_W:    rdata_ext = rdata_word;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/ack data-memory transaction per load/store, min 3 cycles.
// Backpressure: stall holds the core from issue until the DONE cycle; ack timeout bounds it.
module lsu
    import lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TO_BITS = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic [WIDTH-1:0] rdata,
    output logic             ld_valid,
    output logic             misaligned,
    output logic             bus_err,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic             dmem_err,
    input  logic [WIDTH-1:0] dmem_rdata
);

    lsu_state_e         state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [3:0]         be_q, be_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               ld_valid_q, ld_valid_d;
    logic               misaligned_q, misaligned_d;
    logic               bus_err_q, bus_err_d;
    logic [TO_BITS-1:0] cnt_q, cnt_d;
    logic               is_load_q, is_load_d;
    logic [2:0]         ld_f3_q, ld_f3_d;
    logic [1:0]         ld_lo_q, ld_lo_d;

    logic               access;
    logic               bad;
    logic               stall_c;
    logic [3:0]         st_be;
    logic [31:0]        st_wdata;
    logic [31:0]        ld_ext;

    assign access = mem_read | mem_write;

    // Store side sees the live instruction; load side sees what was captured at issue.
    lsu_align u_align (
        .funct3     (funct3),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (st_be),
        .wdata_st   (st_wdata),
        .bad        (bad),
        .ld_funct3  (ld_f3_q),
        .ld_addr_lo (ld_lo_q),
        .rdata_word (dmem_rdata),
        .rdata_ext  (ld_ext)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ld_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            ld_f3_q      <= '0;
            ld_lo_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ld_valid_q   <= ld_valid_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            ld_f3_q      <= ld_f3_d;
            ld_lo_q      <= ld_lo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ld_valid_d   = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        ld_f3_d      = ld_f3_q;
        ld_lo_d      = ld_lo_q;
        stall_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (access && bad) begin
                    misaligned_d = 1'b1;
                    rdata_d      = '0;
                end else if (access) begin
                    stall_c   = 1'b1;
                    req_d     = 1'b1;
                    we_d      = mem_write;
                    be_d      = st_be;
                    addr_d    = {addr[WIDTH-1:2], 2'b00};
                    wdata_d   = st_wdata;
                    cnt_d     = '0;
                    is_load_d = mem_read;
                    ld_f3_d   = funct3;
                    ld_lo_d   = addr[1:0];
                    state_d   = REQ;
                end
            end
            REQ: begin
                stall_c = 1'b1;
                // An ack in the saturation cycle still completes normally.
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (dmem_err) begin
                        bus_err_d = 1'b1;
                        rdata_d   = '0;
                    end else if (is_load_q) begin
                        rdata_d    = ld_ext;
                        ld_valid_d = 1'b1;
                    end
                end else if (cnt_q == {TO_BITS{1'b1}}) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + TO_BITS'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall      = rstn & stall_c;
    assign rdata      = rdata_q;
    assign ld_valid   = ld_valid_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: driver pushes expected bus requests and responses,
// a monitor pops and compares them as the DUT presents them.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, ld_valid, misaligned, bus_err;
    logic [31:0] rdata;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0, dmem_err = 1'b0;
    logic [31:0] dmem_rdata = '0;

    always #5 clk = ~clk;

    lsu #(.WIDTH(32), .TO_BITS(8)) dut (
        .clk(clk), .rstn(rstn), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .ld_valid(ld_valid), .misaligned(misaligned), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_err(dmem_err), .dmem_rdata(dmem_rdata)
    );

    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; int n; } bus_t;
    typedef struct { logic [2:0] kind; logic [31:0] rdata; } resp_t;
    localparam logic [2:0] K_LD = 3'b100, K_ERR = 3'b010, K_MIS = 3'b001;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One instruction, from issue (called just after a posedge) to retirement.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_dly, input logic err, input logic [31:0] word);
        int nb, bits, n, stall_cnt;
        logic legal_ld, legal_st, bad_m, s;
        logic [3:0]  be_m;
        logic [31:0] wd_m, sh, mask, ext;
        bus_t  b;
        resp_t r;

        nb       = 1 << f3[1:0];
        legal_ld = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        legal_st = (f3 <= 3'd2);
        bad_m    = (rd && wr) || (rd && !legal_ld) || (wr && !legal_st) || ((a % nb) != 0);
        be_m     = 4'(((1 << nb) - 1) << (a % 4));
        wd_m     = (nb == 1) ? {24'b0, wd[7:0]} * 32'h01010101 :
                   (nb == 2) ? {16'b0, wd[15:0]} * 32'h00010001 : wd;
        bits     = nb * 8;
        sh       = word >> (8 * (a % 4));
        mask     = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        ext      = sh & mask;
        if (!f3[2] && bits < 32 && sh[bits-1]) ext = ext | ~mask;

        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;

        if (bad_m) begin
            r.kind = K_MIS; r.rdata = '0;
            resp_q.push_back(r);
            @(negedge clk);
            chk("stall_on_bad", {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
            return;
        end

        n = (ack_dly <= 255) ? ack_dly + 1 : 256;
        b.addr = a - (a % 4); b.be = be_m; b.we = wr; b.wdata = wd_m; b.n = n;
        bus_q.push_back(b);
        if (err || ack_dly > 255) begin
            r.kind = K_ERR; r.rdata = '0; resp_q.push_back(r);
        end else if (rd) begin
            r.kind = K_LD; r.rdata = ext; resp_q.push_back(r);
        end

        stall_cnt = 0;
        @(negedge clk);
        if (stall) stall_cnt++;
        @(posedge clk); #1;
        for (int k = 0; k < 300; k++) begin
            if (k == n) begin
                mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
                dmem_ack = 1'($urandom_range(0, 1));
                dmem_err = 1'($urandom_range(0, 1));
            end else begin
                mem_read = 1'($urandom); mem_write = 1'($urandom);
                funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
                dmem_ack = (k == ack_dly);
                dmem_err = (k == ack_dly) && err;
            end
            dmem_rdata = (k == ack_dly) ? word : $urandom;
            @(negedge clk);
            s = stall;
            @(posedge clk); #1;
            dmem_ack = 1'b0; dmem_err = 1'b0;
            if (!s) break;
            stall_cnt++;
        end
        chk("stall_cycles", stall_cnt, n + 1);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // Monitor: bus request capture/stability/length and response pulses.
    initial begin
        logic  prev_req;
        bit    have;
        int    len;
        bus_t  cur;
        resp_t r;
        logic [2:0] pulses;
        prev_req = 1'b0; have = 0; len = 0;
        forever begin
            @(negedge clk);
            if (dmem_req && !prev_req) begin
                len = 0;
                if (bus_q.size() == 0) begin
                    chk("req_unexpected", 32'd1, 32'd0);
                end else begin
                    cur = bus_q.pop_front(); have = 1;
                    chk("req_addr", dmem_addr, cur.addr);
                    chk("req_be", {28'b0, dmem_be}, {28'b0, cur.be});
                    chk("req_we", {31'b0, dmem_we}, {31'b0, cur.we});
                    chk("req_wdata", dmem_wdata, cur.wdata);
                end
            end else if (dmem_req && have) begin
                chk("req_stable", (dmem_addr ^ dmem_wdata) ^ {27'b0, dmem_be, dmem_we},
                    (cur.addr ^ cur.wdata) ^ {27'b0, cur.be, cur.we});
            end
            if (dmem_req) len++;
            if (!dmem_req && prev_req && have) begin
                chk("req_len", len, cur.n);
                have = 0;
            end
            prev_req = dmem_req;

            pulses = {ld_valid, bus_err, misaligned};
            if (pulses != 3'b000) begin
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", {29'b0, pulses}, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_kind", {29'b0, pulses}, {29'b0, r.kind});
                    chk("resp_rdata", rdata, r.rdata);
                    if (r.kind != K_MIS) chk("stall_in_done", {31'b0, stall}, 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic rd, wr;
        int sel;
        bus_t b;

        // Reset with a legal load presented: nothing may leave the unit.
        mem_read = 1'b1; funct3 = F3_W; addr = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_pulses", {29'b0, ld_valid, misaligned, bus_err}, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0; rstn = 1'b1;

        run_op(1'b0, 1'b1, F3_W,  32'h100, 32'hDEADBEEF, 0, 1'b0, 32'h0);
        run_op(1'b1, 1'b0, F3_B,  32'h203, 32'h0, 0, 1'b0, 32'h80123456);
        run_op(1'b1, 1'b0, F3_BU, 32'h203, 32'h0, 2, 1'b0, 32'h80123456);
        run_op(1'b0, 1'b1, F3_H,  32'h102, 32'h00001234, 1, 1'b0, 32'h0);
        run_op(1'b1, 1'b0, F3_W,  32'h101, 32'h0, 0, 1'b0, 32'h0);
        run_op(1'b1, 1'b0, F3_W,  32'h102, 32'h0, 0, 1'b0, 32'h0);
        run_op(1'b1, 1'b1, F3_W,  32'h100, 32'h0, 0, 1'b0, 32'h0);
        run_op(1'b1, 1'b0, F3_W,  32'h104, 32'h0, 1000, 1'b0, 32'h0);
        run_op(1'b1, 1'b0, F3_W,  32'h108, 32'h0, 0, 1'b1, 32'h12345678);
        run_op(1'b1, 1'b0, F3_H,  32'h10A, 32'h0, 255, 1'b0, 32'h80010000);
        run_op(1'b1, 1'b0, F3_HU, 32'h10A, 32'h0, 3, 1'b0, 32'h80010000);

        // Reset in the third REQ cycle; a later ack must not produce a response.
        mem_read = 1'b1; funct3 = F3_W; addr = 32'h300; wdata = 32'h0;
        b.addr = 32'h300; b.be = 4'hF; b.we = 1'b0; b.wdata = 32'h0; b.n = 3;
        bus_q.push_back(b);
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("stall_in_reset", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("req_after_reset", {31'b0, dmem_req}, 32'd0);
        chk("rdata_after_reset", rdata, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("stall_late_ack", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel < 5) || (sel == 9);
            wr  = (sel >= 5);
            run_op(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom_range(0, 4), ($urandom_range(0, 7) == 0), $urandom);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("resp_q_drained", resp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the execution unit in the single-cycle core.
- Consumes the ALU result as the effective address and Rd2 as store data, then runs a req/ack transaction on the data-memory bus.
- Holds the core with `stall` until the access completes, and returns sign/zero-extended load data to the register-file writeback mux.
- Handles byte-lane steering, misalignment detection, bus errors and a watchdog timeout.

Parameters:
- WIDTH, 32, data/address width (only 32 supported)
- TO_BITS, 8, width of the ack-timeout counter; timeout fires after 2^TO_BITS-1 cycles in REQ

Ports:
- clk  in  1  core clock
- rstn  in  1  reset, synchronous, active-low
- mem_read  in  1  decoder: current instruction is a load
- mem_write  in  1  decoder: current instruction is a store
- funct3  in  3  instruction funct3 (access size/signedness)
- addr  in  32  effective address (alu_result)
- wdata  in  32  store data (Rd2)
- stall  out  1  freeze PC/regfile write while high
- rdata  out  32  extended load data, valid when ld_valid=1
- ld_valid  out  1  one-cycle pulse: load data valid
- misaligned  out  1  one-cycle pulse: misaligned or illegal access, no bus cycle issued
- bus_err  out  1  one-cycle pulse: dmem_err or timeout
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  write enable, registered
- dmem_be  out  4  byte enables, registered
- dmem_addr  out  32  word address {addr[31:2],2'b00}, registered
- dmem_wdata  out  32  lane-steered store data, registered
- dmem_ack  in  1  bus completion
- dmem_err  in  1  bus error, qualified by dmem_ack
- dmem_rdata  in  32  read word, qualified by dmem_ack

Behaviour:
- Reset, on the clk edge with rstn=0:
  - state=IDLE.
  - All registered outputs 0: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, rdata, ld_valid, misaligned, bus_err.
  - Timeout counter 0.
  - stall=0 while rstn=0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - `access = mem_read | mem_write`.
  - stall = access & ~bad (combinational).
  - `bad` is any of:
    - misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0;
    - illegal funct3: load not in {000,001,010,100,101}, or store not in {000,001,010};
    - mem_read & mem_write both high.
  - If bad: pulse misaligned next cycle, rdata=0, stay IDLE, no bus activity.
  - If access & ~bad: register dmem_addr, dmem_be, dmem_wdata and dmem_we=mem_write; set dmem_req=1; go to REQ.
- REQ:
  - stall=1; dmem_req held 1 with all bus outputs stable until dmem_ack.
  - On dmem_ack:
    - drop dmem_req next cycle;
    - if dmem_err: bus_err pulse, rdata=0;
    - else for a load: rdata = extended lane data and ld_valid pulse;
    - go to DONE.
  - Counter increments each REQ cycle without ack. At all-ones it forces: bus_err pulse, rdata=0, dmem_req drop, go to DONE. The counter clears on REQ entry.
- DONE:
  - stall=0, so the core retires the instruction this cycle with rdata valid; ld_valid/bus_err high this cycle only.
  - Unconditionally go to IDLE. The same instruction is never re-issued, because the PC advances at the DONE edge.
- Store lane steering:
  - SB: be=0001<<addr[1:0], data={4{wdata[7:0]}}.
  - SH: be=0011 if addr[1]=0 else 1100, data={2{wdata[15:0]}}.
  - SW: be=1111, data=wdata.
- Load extraction:
  - Select byte addr[1:0] or halfword addr[1] from dmem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Latency: minimum 3 cycles for an access with ack in the first REQ cycle: IDLE→REQ→DONE.
- Boundary conditions:
  - dmem_ack in IDLE or DONE (stale/late) is ignored.
  - Ack on the same cycle the counter saturates: ack wins, no bus_err unless dmem_err.
  - Reset mid-REQ: dmem_req drops at the reset edge; a late ack after reset is ignored.
  - mem_read/mem_write changing while in REQ are ignored; inputs are captured at IDLE.

Decomposition:
- Shared package `lsu_pkg`:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding IDLE/REQ/DONE;
  - BE constants.
- One combinational sub-module `lsu_align`:
  - store steering: funct3, addr[1:0], wdata → be, steered data, bad;
  - load extraction: funct3, addr[1:0], dmem_rdata → extended data.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, ack in 1st REQ cycle → dmem_addr=0x100, be=1111, we=1; stall high 2 cycles; no ld_valid.
- LB addr=0x203, rdata=0x80xxxxxx → be=1000, rdata=0xFFFFFF80; LBU on the same word → 0x00000080; ld_valid one cycle in DONE.
- SH addr=0x102 wdata=0x1234 → be=1100, dmem_wdata=0x12341234.
- LW addr=0x101 → misaligned pulse, dmem_req never asserted, stall=0. Repeat with LW addr=0x102 (misaligned) and with mem_read=mem_write=1 (illegal); both give the same response.
- LW with ack withheld → bus_err at counter=255, rdata=0, DONE then IDLE. Separately, ack with dmem_err=1 → bus_err, no ld_valid.
- Reset asserted in REQ for 1 cycle → dmem_req=0 next cycle, state IDLE; ack 2 cycles later ignored (no ld_valid).
